// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcode/funct constants, ALU/PC-source/cause encodings and the control word.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W  = 5;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned ASB_W    = 2;
    localparam int unsigned CAUSE_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 5'd0,
        ST_FETCH     = 5'd1,
        ST_DECODE    = 5'd2,
        ST_EXEC_R    = 5'd3,
        ST_WB_R      = 5'd4,
        ST_ADDI_EXEC = 5'd5,
        ST_ADDI_WB   = 5'd6,
        ST_MEM_ADDR  = 5'd7,
        ST_LW_READ   = 5'd8,
        ST_LW_WB     = 5'd9,
        ST_SW_WRITE  = 5'd10,
        ST_BEQ       = 5'd11,
        ST_JUMP      = 5'd12,
        ST_TRAP      = 5'd13
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [ASB_W-1:0] ASB_B      = 2'b00;
    localparam logic [ASB_W-1:0] ASB_FOUR   = 2'b01;
    localparam logic [ASB_W-1:0] ASB_IMM    = 2'b10;
    localparam logic [ASB_W-1:0] ASB_IMM_SH = 2'b11;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_INVALID = 2'b01,
        CAUSE_OVF     = 2'b10
    } cause_e;

    // Every datapath enable/select driven by the controller, in one word.
    typedef struct packed {
        logic                reset_out;
        logic                pc_write;
        logic                pc_write_cond;
        logic [PC_SRC_W-1:0] pc_src;
        logic                iord;
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                reg_write;
        logic                alu_src_a;
        logic [ASB_W-1:0]    alu_src_b;
        alu_op_e             alu_op;
        logic                epc_write;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Instruction-register / datapath interface of the multicycle control unit.
// master: controller side, slave: datapath side.
interface mc_ctrl_fsm_if;
    import mc_ctrl_pkg::*;

    logic [OP_W-1:0]     opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                alu_zero;
    logic                alu_ovf;
    logic                reset_out;
    logic                pc_write;
    logic                pc_write_cond;
    logic [PC_SRC_W-1:0] pc_src;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [ASB_W-1:0]    alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                epc_write;
    logic [CAUSE_W-1:0]  cause;
    logic [STATE_W-1:0]  state_out;

    modport master (
        input  opcode, funct, alu_zero, alu_ovf,
        output reset_out, pc_write, pc_write_cond, pc_src, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, epc_write, cause, state_out
    );

    modport slave (
        output opcode, funct, alu_zero, alu_ovf,
        input  reset_out, pc_write, pc_write_cond, pc_src, iord, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
               alu_src_b, alu_op, epc_write, cause, state_out
    );

endinterface

// File: rtl/mc_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unknown codes.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output alu_op_e            alu_op_c,
    output logic               valid_c
);

    always_comb begin
        alu_op_c = ALU_ADD;
        valid_c  = 1'b1;
        case (funct)
            FN_ADD:  alu_op_c = ALU_ADD;
            FN_SUB:  alu_op_c = ALU_SUB;
            FN_AND:  alu_op_c = ALU_AND;
            FN_OR:   alu_op_c = ALU_OR;
            FN_SLT:  alu_op_c = ALU_SLT;
            default: valid_c  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with post-reset hold, memory wait and trap state.
// Define CTRL_OVF_TRAP_EN to trap on signed overflow of add/sub/addi (cause 10).
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned         RESET_CYCLES   = 2,
    parameter int unsigned         MEM_LAT        = 1,
    parameter int unsigned         CNT_W          = 3,
    parameter logic [PC_SRC_W-1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_e           cause_q, cause_d;
    ctrl_t            ctrl_q, ctrl_d;
    alu_op_e          dec_op;
    logic             dec_valid;
    logic             hold_done;
    logic             hold_done_d;

`ifdef CTRL_OVF_TRAP_EN
    logic ovf_q, ovf_d;
`endif

    mc_alu_dec u_alu_dec (
        .funct    (bus.funct),
        .alu_op_c (dec_op),
        .valid_c  (dec_valid)
    );

    assign hold_done = (cnt_q == CNT_W'(MEM_LAT));

    // Next state, trap cause and wait counter; synchronous reset folds in here.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
`ifdef CTRL_OVF_TRAP_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_RESET: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (hold_done) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: state_d = ST_EXEC_R;
                    OP_ADDI:  state_d = ST_ADDI_EXEC;
                    OP_LW,
                    OP_SW:    state_d = ST_MEM_ADDR;
                    OP_BEQ:   state_d = ST_BEQ;
                    OP_J:     state_d = ST_JUMP;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_INVALID;
                    end
                endcase
            end
            ST_EXEC_R: begin
                if (!dec_valid) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_INVALID;
                end else begin
                    state_d = ST_WB_R;
                end
`ifdef CTRL_OVF_TRAP_EN
                // Overflow is captured while the ALU is computing the result.
                ovf_d = bus.alu_ovf && ((bus.funct == FN_ADD) || (bus.funct == FN_SUB));
`endif
            end
            ST_ADDI_EXEC: begin
                state_d = ST_ADDI_WB;
`ifdef CTRL_OVF_TRAP_EN
                ovf_d = bus.alu_ovf;
`endif
            end
            ST_WB_R,
            ST_ADDI_WB: begin
`ifdef CTRL_OVF_TRAP_EN
                if (ovf_q) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = ST_FETCH;
                end
`else
                state_d = ST_FETCH;
`endif
            end
            ST_MEM_ADDR: begin
                state_d = (bus.opcode == OP_LW) ? ST_LW_READ : ST_SW_WRITE;
            end
            ST_LW_READ: begin
                if (hold_done) state_d = ST_LW_WB;
            end
            ST_SW_WRITE: begin
                if (hold_done) state_d = ST_FETCH;
            end
            ST_LW_WB,
            ST_BEQ,
            ST_JUMP,
            ST_TRAP: state_d = ST_FETCH;
            default: state_d = ST_RESET;
        endcase

        if (reset) begin
            state_d = ST_RESET;
            cause_d = CAUSE_NONE;
`ifdef CTRL_OVF_TRAP_EN
            ovf_d   = 1'b0;
`endif
        end

        if (reset || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign hold_done_d = (cnt_d == CNT_W'(MEM_LAT));

    // Control word for the state being entered, so outputs come straight from flops.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            ST_RESET: ctrl_d.reset_out = 1'b1;
            ST_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = ASB_FOUR;
                if (hold_done_d) begin
                    ctrl_d.ir_write = 1'b1;
                    ctrl_d.pc_write = 1'b1;
                    ctrl_d.pc_src   = PC_SRC_ALU;
                end
            end
            ST_DECODE: ctrl_d.alu_src_b = ASB_IMM_SH;
            ST_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = ASB_B;
                ctrl_d.alu_op    = dec_op;
            end
            ST_WB_R: begin
                ctrl_d.reg_dst   = 1'b1;
`ifdef CTRL_OVF_TRAP_EN
                ctrl_d.reg_write = !ovf_d;
`else
                ctrl_d.reg_write = 1'b1;
`endif
            end
            ST_ADDI_EXEC,
            ST_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = ASB_IMM;
            end
            ST_ADDI_WB: begin
`ifdef CTRL_OVF_TRAP_EN
                ctrl_d.reg_write = !ovf_d;
`else
                ctrl_d.reg_write = 1'b1;
`endif
            end
            ST_LW_READ: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.iord     = 1'b1;
            end
            ST_LW_WB: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            ST_SW_WRITE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.iord      = 1'b1;
            end
            ST_BEQ: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_src_b     = ASB_B;
                ctrl_d.alu_op        = ALU_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_src        = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_d.pc_write = 1'b1;
                ctrl_d.pc_src   = PC_SRC_JUMP;
            end
            ST_TRAP: begin
                ctrl_d.epc_write = 1'b1;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_src    = EXC_VECTOR_SEL;
            end
            default: ctrl_d.reset_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cause_q <= cause_d;
        ctrl_q  <= ctrl_d;
`ifdef CTRL_OVF_TRAP_EN
        ovf_q   <= ovf_d;
`endif
    end

    assign bus.reset_out     = ctrl_q.reset_out;
    assign bus.pc_write      = ctrl_q.pc_write;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.pc_src        = ctrl_q.pc_src;
    assign bus.iord          = ctrl_q.iord;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.ir_write      = ctrl_q.ir_write;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.epc_write     = ctrl_q.epc_write;
    assign bus.cause         = cause_q;
    assign bus.state_out     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed and random instructions compared cycle by
// cycle against per-instruction expected traces built from the opcode table.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam int unsigned RESET_CYCLES = 2;
    localparam int unsigned MEM_LAT      = 1;
    localparam int unsigned CNT_W        = 3;
    localparam logic [1:0]  EXC_SEL      = 2'b11;
`ifdef CTRL_OVF_TRAP_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic       reset_out;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       epc_write;
    } tb_ctl_t;

    typedef struct {
        state_e     st;
        tb_ctl_t    ctl;
        logic [1:0] cause;
        bit         alu_care;
    } ent_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    ent_t tr[$];
    logic [1:0] exp_cause;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(
        .RESET_CYCLES   (RESET_CYCLES),
        .MEM_LAT        (MEM_LAT),
        .CNT_W          (CNT_W),
        .EXC_VECTOR_SEL (EXC_SEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic tb_ctl_t obs_ctl();
        tb_ctl_t c;
        c = {bus.reset_out, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.iord,
             bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.epc_write};
        return c;
    endfunction

    function automatic bit ref_alu(input logic [5:0] fn, output logic [2:0] op);
        op = 3'b000;
        case (fn)
            6'h20: begin op = 3'b000; return 1'b1; end
            6'h22: begin op = 3'b001; return 1'b1; end
            6'h24: begin op = 3'b010; return 1'b1; end
            6'h25: begin op = 3'b011; return 1'b1; end
            6'h2A: begin op = 3'b100; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic void add_ent(input state_e s, input tb_ctl_t c, input bit care);
        ent_t e;
        e.st = s; e.ctl = c; e.cause = exp_cause; e.alu_care = care;
        tr.push_back(e);
    endfunction

    function automatic void add_trap(input logic [1:0] why);
        tb_ctl_t c;
        exp_cause = why;
        c = '0; c.epc_write = 1'b1; c.pc_write = 1'b1; c.pc_src = EXC_SEL;
        add_ent(ST_TRAP, c, 1'b1);
    endfunction

    // Expected cycle-by-cycle trace of one instruction, starting at its first FETCH cycle.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input bit ovf);
        tb_ctl_t c;
        logic [2:0] aop;
        bit valid, trap_ovf;
        for (int k = 0; k <= int'(MEM_LAT); k++) begin
            c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
            if (k == int'(MEM_LAT)) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
            add_ent(ST_FETCH, c, 1'b1);
        end
        c = '0; c.alu_src_b = 2'b11;
        add_ent(ST_DECODE, c, 1'b1);
        case (op)
            6'h00: begin
                valid = ref_alu(fn, aop);
                c = '0; c.alu_src_a = 1'b1; c.alu_op = aop;
                add_ent(ST_EXEC_R, c, valid);
                if (!valid) add_trap(2'b01);
                else begin
                    trap_ovf = OVF_EN && ovf && (fn == 6'h20 || fn == 6'h22);
                    c = '0; c.reg_dst = 1'b1; c.reg_write = !trap_ovf;
                    add_ent(ST_WB_R, c, 1'b1);
                    if (trap_ovf) add_trap(2'b10);
                end
            end
            6'h08: begin
                trap_ovf = OVF_EN && ovf;
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                add_ent(ST_ADDI_EXEC, c, 1'b1);
                c = '0; c.reg_write = !trap_ovf;
                add_ent(ST_ADDI_WB, c, 1'b1);
                if (trap_ovf) add_trap(2'b10);
            end
            6'h23, 6'h2B: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                add_ent(ST_MEM_ADDR, c, 1'b1);
                for (int k = 0; k <= int'(MEM_LAT); k++) begin
                    c = '0; c.iord = 1'b1;
                    if (op == 6'h23) c.mem_read = 1'b1; else c.mem_write = 1'b1;
                    add_ent(op == 6'h23 ? ST_LW_READ : ST_SW_WRITE, c, 1'b1);
                end
                if (op == 6'h23) begin
                    c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
                    add_ent(ST_LW_WB, c, 1'b1);
                end
            end
            6'h04: begin
                c = '0; c.alu_src_a = 1'b1; c.alu_op = 3'b001;
                c.pc_write_cond = 1'b1; c.pc_src = 2'b01;
                add_ent(ST_BEQ, c, 1'b1);
            end
            6'h02: begin
                c = '0; c.pc_write = 1'b1; c.pc_src = 2'b10;
                add_ent(ST_JUMP, c, 1'b1);
            end
            default: add_trap(2'b01);
        endcase
    endfunction

    task automatic check_cycle(input ent_t e, input string tag);
        tb_ctl_t mask;
        mask = '1;
        if (!e.alu_care) mask.alu_op = 3'b000;
        check({tag, " state"}, 32'(bus.state_out), 32'(e.st));
        check({tag, " ctl"}, 32'(obs_ctl() & mask), 32'(e.ctl & mask));
        check({tag, " cause"}, 32'(bus.cause), 32'(e.cause));
    endtask

    task automatic check_reset_cycle(input string tag);
        ent_t e;
        e.st = ST_RESET; e.ctl = '0; e.ctl.reset_out = 1'b1;
        e.cause = 2'b00; e.alu_care = 1'b1;
        check_cycle(e, tag);
    endtask

    // Hold reset for n edges, release, then expect the post-reset hold.
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); check_reset_cycle($sformatf("rst c%0d", i));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        exp_cause = 2'b00;
        for (int i = 0; i < int'(RESET_CYCLES); i++) begin
            @(negedge clk); check_reset_cycle($sformatf("rst_hold c%0d", i));
            @(posedge clk); #1;
        end
    endtask

    // abort_at: -1 none, -2 random cycle, else trace index at which reset is raised.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit ovf,
                             input int abort_at, input int idx);
        int ab;
        tr.delete();
        build(op, fn, ovf);
        ab = (abort_at == -2) ? int'($urandom_range(0, tr.size() - 1)) : abort_at;
        bus.opcode   = op;
        bus.funct    = fn;
        bus.alu_ovf  = ovf;
        bus.alu_zero = 1'($urandom_range(0, 1));
        for (int i = 0; i < tr.size(); i++) begin
            if (i == ab) reset = 1'b1;
            @(negedge clk);
            check_cycle(tr[i], $sformatf("i%0d op%0h fn%0h c%0d", idx, op, fn, i));
            @(posedge clk); #1;
            if (i == ab) begin
                do_reset(2);
                return;
            end
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        n_checks = 0;
        n_fail = 0;
        exp_cause = 2'b00;
        reset = 1'b1;
        bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.alu_ovf = 1'b0;

        do_reset(3);

        run_instr(6'h00, 6'h20, 1'b0, -1, 0);
        run_instr(6'h23, 6'h00, 1'b0, -1, 1);
        run_instr(6'h2B, 6'h11, 1'b0, -1, 2);
        run_instr(6'h04, 6'h00, 1'b0, -1, 3);
        run_instr(6'h02, 6'h00, 1'b0, -1, 4);
        run_instr(6'h3F, 6'h20, 1'b0, -1, 5);
        run_instr(6'h00, 6'h3F, 1'b0, -1, 6);
        run_instr(6'h08, 6'h00, 1'b0, -1, 7);
        run_instr(6'h00, 6'h22, 1'b1, -1, 8);
        run_instr(6'h08, 6'h00, 1'b1, -1, 9);
        run_instr(6'h00, 6'h2A, 1'b1, -1, 10);
        run_instr(6'h00, 6'h3F, 1'b0, -1, 11);
        // Reset in the first LW_READ cycle (after 2 FETCH, DECODE, MEM_ADDR).
        run_instr(6'h23, 6'h00, 1'b0, int'(MEM_LAT) + 3, 12);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = fns[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0) ? -2 : -1, 100 + n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Parametrised multicycle MIPS control unit. Moore FSM that sequences fetch, decode, execute, memory and writeback for R-type (add, sub, and, or, slt), addi, lw, sw, beq and j. Adds a post-reset hold, fixed-latency memory wait and invalid-instruction trap. Sits between the instruction register and the datapath; drives every datapath enable and mux select.

Parameters:
RESET_CYCLES, 2, cycles reset_out stays high after reset deasserts (1..2^CNT_W-1)
MEM_LAT, 1, extra wait cycles each memory-access state is held (0..2^CNT_W-1)
CNT_W, 3, width of internal wait/hold counter
EXC_VECTOR_SEL, 2'b11, pc_src value selecting the exception vector

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag (beq)
alu_ovf  in  1  ALU signed overflow flag
reset_out  out  1  datapath register reset
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if alu_zero
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, EXC_VECTOR_SEL vector
iord  out  1  0 PC, 1 ALUOut as memory address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  register file write
alu_src_a  out  1  0 PC, 1 A
alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
epc_write  out  1  EPC load
cause  out  2  00 none, 01 invalid instr, 10 overflow; registered, held until next trap
state_out  out  5  current state code (debug)

Behaviour:
- Reset: clock clk; reset synchronous, active-high. While reset=1: state=RESET, counter=0, cause=00. In RESET: reset_out=1, all other controls 0.
- After reset falls: RESET_CYCLES further cycles in RESET (reset_out=1), then FETCH. Reset mid-instruction aborts immediately at next edge; no writes in the reset cycle.
- Outputs are pure functions of state (and counter where noted); unlisted outputs 0 in each state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000. Held MEM_LAT+1 cycles; only on last cycle ir_write=1, pc_write=1, pc_src=00. Then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target). Next: R->EXEC_R, addi->ADDI_EXEC, lw/sw->MEM_ADDR, beq->BEQ, j->JUMP, else TRAP (cause=01).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt); unknown funct -> TRAP (cause=01), else WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000 -> ADDI_WB: reg_dst=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 -> LW_READ or SW_WRITE.
- LW_READ: mem_read=1, iord=1, held MEM_LAT+1 cycles -> LW_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- SW_WRITE: mem_write=1, iord=1, held MEM_LAT+1 cycles -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01 -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- TRAP: one cycle; epc_write=1, pc_write=1, pc_src=EXC_VECTOR_SEL -> FETCH. cause register written on entry.
- Counter: cleared on every state change; increments while held; wraps never (bounded by parameter).
- Illegal state encoding -> RESET behaviour next cycle.

Optional Feature:
CTRL_OVF_TRAP_EN. Defined: in WB_R (add/sub) and ADDI_WB, if alu_ovf=1 then reg_write=0 and next state TRAP with cause=10. Undefined: alu_ovf ignored, result written, no overflow trap; cause never 10.

Decomposition:
- Shared package mc_ctrl_pkg: state codes, opcode/funct constants, alu_op, pc_src and cause encodings.
- Sub-module mc_alu_dec: combinational funct->alu_op/valid decoder, reused by EXEC_R.

Test Plan:
- reset high 3 cycles, low; RESET_CYCLES=2 -> reset_out=1 for 2 cycles after fall, then state FETCH, mem_read=1.
- add (opcode 0, funct 0x20), MEM_LAT=1 -> FETCH 2 cycles, DECODE, EXEC_R alu_op=000, WB_R reg_write=1 reg_dst=1; 5 cycles total.
- lw (0x23) -> LW_READ mem_read=1 iord=1 for 2 cycles, LW_WB mem_to_reg=1; sw (0x2B) -> mem_write 2 cycles, no reg_write.
- beq (0x04) with alu_zero=1 -> pc_write_cond=1, pc_src=01, alu_op=001; j (0x02) -> pc_write=1, pc_src=10.
- opcode 0x3F -> TRAP: epc_write=1, pc_src=11, cause=01; R-type funct 0x3F -> same.
- with CTRL_OVF_TRAP_EN, add with alu_ovf=1 -> reg_write=0, cause=10; reset asserted during LW_READ -> RESET next edge, mem_read=0.
